// File: rtl/instr_sequencer.sv
// instr_sequencer: program buffer + issue engine feeding simple_cpu's 20-bit
// instruction input. The host loads words over a valid/ready handshake. On
// start, each word is issued in its own slot of 1+ISSUE_GAP cycles. A word
// whose opcode is HALT_OP ends the run without being issued.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   load_valid/data   host program word in; load_ready is combinational
//   clear             empty the buffer (honoured in IDLE/DONE only)
//   start             begin a run (from IDLE/DONE); in loop builds, also stops a run
//   instruction       registered word to the CPU (NOP_WORD when not issuing)
//   issue_strobe      one-cycle pulse in the first cycle of each slot
//   pc, count         slot index being issued / number of words loaded
//   busy, done        high in ISSUE/HOLD, high in DONE
//
// Build option: define INSTR_SEQ_LOOP_EN to wrap pc after the last word and run
// until start is pulsed again or a HALT word is reached.
module instr_sequencer #(
  parameter int                     INSTR_WIDTH = 20,
  parameter int                     DEPTH_BITS  = 4,
  parameter int                     ISSUE_GAP   = 3,
  parameter logic [3:0]             HALT_OP     = 4'hF,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  input  logic [INSTR_WIDTH-1:0] load_data,
  output logic                   load_ready,
  input  logic                   clear,
  input  logic                   start,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   issue_strobe,
  output logic [DEPTH_BITS-1:0]  pc,
  output logic [DEPTH_BITS:0]    count,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DONE} state_t;

  localparam logic [7:0]            GAP    = 8'(ISSUE_GAP);
  localparam logic [DEPTH_BITS:0]   CNT_1  = 1;
  localparam logic [DEPTH_BITS-1:0] PC_1   = 1;

  state_t                   state, state_n;
  logic [INSTR_WIDTH-1:0]   mem [2**DEPTH_BITS];
  logic [INSTR_WIDTH-1:0]   instr_n, entry_word;
  logic [DEPTH_BITS-1:0]    pc_n, entry_idx;
  logic [DEPTH_BITS:0]      count_n;
  logic [7:0]               gap, gap_n;
  logic                     strobe_n, load_fire, last, in_run, do_entry, end_slot, go_done;
`ifdef INSTR_SEQ_LOOP_EN
  logic                     stop, stop_n;
`endif

  // Full when the extra count bit is set (count == 2**DEPTH_BITS).
  assign load_ready = (state == IDLE) && !count[DEPTH_BITS];
  assign load_fire  = load_valid && load_ready;
  assign in_run     = (state == ISSUE) || (state == HOLD);
  assign last       = ({1'b0, pc} == (count - CNT_1));

  // Next slot index: successor while running, otherwise 0 (fresh run or wrap).
  assign entry_idx  = (in_run && !last) ? pc + PC_1 : '0;
  // Bypass covers a start arriving in the same cycle as the first load.
  assign entry_word = (load_fire && count[DEPTH_BITS-1:0] == entry_idx) ? load_data : mem[entry_idx];

  always_ff @(posedge clk)
    if (load_fire) mem[count[DEPTH_BITS-1:0]] <= load_data;

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    count_n  = count;
    instr_n  = instruction;
    strobe_n = 1'b0;
    gap_n    = gap;
    do_entry = 1'b0;
    end_slot = 1'b0;
    go_done  = 1'b0;
`ifdef INSTR_SEQ_LOOP_EN
    stop_n   = stop;
`endif
    if (load_fire) count_n = count + CNT_1;

    case (state)
      IDLE:  if (clear) count_n = '0;
             else if (start && count_n != '0) do_entry = 1'b1;
      ISSUE: if (GAP == 8'd0) end_slot = 1'b1;
             else begin state_n = HOLD; gap_n = GAP; end
      HOLD:  if (gap == 8'd1) end_slot = 1'b1;
             else gap_n = gap - 8'd1;
      DONE:  if (clear) begin state_n = IDLE; count_n = '0; end
             else if (start) do_entry = 1'b1;
      default: state_n = IDLE;
    endcase

`ifdef INSTR_SEQ_LOOP_EN
    if (in_run && start) stop_n = 1'b1;
    // A start in the slot's final cycle also counts toward stopping.
    if (end_slot) begin
      if (stop || start) go_done = 1'b1;
      else               do_entry = 1'b1;
    end
`else
    if (end_slot) begin
      if (last) go_done = 1'b1;
      else      do_entry = 1'b1;
    end
`endif

    if (do_entry) begin
      pc_n = entry_idx;
      if (entry_word[INSTR_WIDTH-1 -: 4] == HALT_OP) go_done = 1'b1;
      else begin
        state_n  = ISSUE;
        instr_n  = entry_word;
        strobe_n = 1'b1;
      end
    end

    if (go_done) begin
      state_n = DONE;
      instr_n = NOP_WORD;
`ifdef INSTR_SEQ_LOOP_EN
      stop_n  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= '0;
      count        <= '0;
      instruction  <= NOP_WORD;
      issue_strobe <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      gap          <= '0;
`ifdef INSTR_SEQ_LOOP_EN
      stop         <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      count        <= count_n;
      instruction  <= instr_n;
      issue_strobe <= strobe_n;
      busy         <= (state_n == ISSUE) || (state_n == HOLD);
      done         <= (state_n == DONE);
      gap          <= gap_n;
`ifdef INSTR_SEQ_LOOP_EN
      stop         <= stop_n;
`endif
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: each run pushes the words the program
// should issue; a negedge monitor pops and compares on every issue_strobe.
module tb_instr_sequencer;
  localparam int W = 20, DB = 4, GAP = 3, DEPTH = 16;

  logic          clk = 1'b0, rst, load_valid, clear, start;
  logic [W-1:0]  load_data, instruction;
  logic          load_ready, issue_strobe, busy, done;
  logic [DB-1:0] pc;
  logic [DB:0]   count;

  instr_sequencer #(.INSTR_WIDTH(W), .DEPTH_BITS(DB), .ISSUE_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .clear(clear), .start(start),
    .instruction(instruction), .issue_strobe(issue_strobe), .pc(pc),
    .count(count), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] word; logic [DB-1:0] idx; } exp_t;
  exp_t sb[$];
  int   errors = 0, checks = 0, cyc = 0, last_strobe = 0;
  bit   first_of_run = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (!rst && issue_strobe) begin
      if (sb.size() == 0) chk("unexpected_strobe", instruction, 32'hDEAD_BEEF);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_word", instruction, e.word);
        chk("strobe_pc", pc, e.idx);
      end
      if (!first_of_run) chk("strobe_spacing", cyc - last_strobe, 1 + GAP);
      first_of_run = 1'b0;
      last_strobe  = cyc;
    end
  end

  function automatic logic [W-1:0] rand_word(input bit halt);
    logic [W-1:0] w;
    w = W'($urandom);
    w[W-1 -: 4] = halt ? 4'hF : 4'($urandom_range(0, 14));
    return w;
  endfunction

  task automatic load_word(input logic [W-1:0] w);
    load_valid = 1'b1; load_data = w;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic load_prog(input logic [W-1:0] p[$], input bit gaps);
    foreach (p[i]) begin
      load_word(p[i]);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Reference: words issue in order until the first HALT opcode or the end;
  // pc finishes on the HALT index or on the last word.
  task automatic expect_run(input logic [W-1:0] p[$], output int last_idx);
    last_idx = p.size() - 1;
    foreach (p[i]) begin
      if (p[i][W-1 -: 4] == 4'hF) begin last_idx = i; break; end
      sb.push_back('{word: p[i], idx: DB'(i)});
    end
  endtask

  task automatic pulse(input bit c, input bit s);
    clear = c; start = s;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    chk(name, done, 1);
  endtask

  task automatic run(input string name, input logic [W-1:0] p[$]);
    int li;
    expect_run(p, li);
    first_of_run = 1'b1;
    pulse(1'b0, 1'b1);
    wait_done({name, "_done"});
    chk({name, "_nop"}, instruction, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_pc"}, pc, li);
    chk({name, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    logic [W-1:0] p[$];
    int n, seen;
    rst = 1'b1; load_valid = 1'b0; load_data = '0; clear = 1'b0; start = 1'b0;
    #12;
    chk("rst_pc", pc, 0);           chk("rst_count", count, 0);
    chk("rst_instr", instruction, 0); chk("rst_strobe", issue_strobe, 0);
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_ready", load_ready, 1);
    @(negedge clk); rst = 1'b0;

    // Directed 3-word run.
    p = '{20'h10203, 20'h21104, 20'h30001};
    load_prog(p, 1'b0);
    chk("load3_count", count, 3);
    run("basic", p);

    // clear+start in DONE: clear wins.
    pulse(1'b1, 1'b1);
    chk("clrstart_done", done, 0); chk("clrstart_count", count, 0);
    chk("clrstart_busy", busy, 0); chk("clrstart_ready", load_ready, 1);

    // start with an empty buffer is ignored.
    pulse(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("empty_start_busy", busy, 0); chk("empty_start_ready", load_ready, 1);
    chk("empty_start_done", done, 0);

    // Fill to capacity, then offer a 17th word that must be refused.
    p = {};
    for (int i = 0; i < DEPTH; i++) p.push_back(rand_word(1'b0));
    load_prog(p, 1'b0);
    chk("full_ready", load_ready, 0); chk("full_count", count, DEPTH);
    load_valid = 1'b1; load_data = 20'h5ABCD;
    repeat (2) @(negedge clk);
    load_valid = 1'b0;
    chk("overflow_count", count, DEPTH);
    run("full", p);
    pulse(1'b1, 1'b0);

    // HALT in the middle stops the run before it.
    p = '{20'h10001, 20'hF0000, 20'h20002};
    load_prog(p, 1'b0);
    run("halt", p);
    pulse(1'b1, 1'b0);

    // Randomized programs, some containing a HALT word.
    for (int r = 0; r < 6; r++) begin
      p = {};
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) p.push_back(rand_word($urandom_range(0, 9) == 0));
      load_prog(p, 1'b1);
      chk("rand_count", count, n);
      run("rand", p);
      pulse(1'b1, 1'b0);
    end

    // Reset in the HOLD phase of slot 2 aborts immediately.
    p = '{20'h10203, 20'h21104, 20'h30001};
    load_prog(p, 1'b0);
    expect_run(p, n);
    first_of_run = 1'b1;
    pulse(1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      if (issue_strobe) seen++;
      if (seen < 2) @(negedge clk);
    end
    chk("midrun_two_strobes", seen, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_instr", instruction, 0); chk("midrun_pc", pc, 0);
    chk("midrun_count", count, 0);       chk("midrun_busy", busy, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", busy, 0); chk("post_rst_done", done, 0);

`ifdef INSTR_SEQ_LOOP_EN
    // Loop mode: two words repeat until start is pulsed in slot 4.
    p = '{20'h1AAAA, 20'h2BBBB};
    load_prog(p, 1'b0);
    for (int k = 0; k < 4; k++) sb.push_back('{word: p[k % 2], idx: DB'(k % 2)});
    first_of_run = 1'b1;
    pulse(1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 60 && seen < 4; i++) begin
      if (issue_strobe) seen++;
      if (seen < 4) @(negedge clk);
    end
    chk("loop_four_strobes", seen, 4);
    pulse(1'b0, 1'b1);
    wait_done("loop_done");
    chk("loop_pc", pc, 1); chk("loop_drained", sb.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Producer end of the 20-bit `instruction` interface that simple_cpu consumes.
- A host streams program words into a local program buffer through a valid/ready handshake.
- On `start`, the block issues the words to the CPU in order, one per fixed-length issue slot, giving the multi-cycle CU time per instruction.
- Sits between the test/host harness and simple_cpu; its `instruction` output wires directly to the CPU `instruction` input.

Parameters:
- INSTR_WIDTH, 20, instruction word width; bits [INSTR_WIDTH-1:INSTR_WIDTH-4] are the opcode field.
- DEPTH_BITS, 4, program buffer address bits (2**DEPTH_BITS words, default 16).
- ISSUE_GAP, 3, hold cycles after the strobe cycle; slot length = 1+ISSUE_GAP cycles. Legal range 0..255.
- HALT_OP, 4'hF, opcode value that terminates a run.
- NOP_WORD, 20'h00000, word driven whenever no instruction is being issued.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  host word valid.
- load_data  in  INSTR_WIDTH  host program word.
- load_ready  out  1  buffer accepts a word this cycle.
- clear  in  1  empty the program buffer (IDLE/DONE only).
- start  in  1  begin execution; with LOOP_EN also stops a running loop.
- instruction  out  INSTR_WIDTH  word to CPU, registered.
- issue_strobe  out  1  one-cycle pulse in the first cycle of each slot.
- pc  out  DEPTH_BITS  index of the word currently issued.
- count  out  DEPTH_BITS+1  number of words loaded.
- busy  out  1  high in ISSUE/HOLD.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - pc=0, count=0, instruction=NOP_WORD, issue_strobe=0, busy=0, done=0, load_ready=1.
  - Buffer contents are don't-care.
  - Reset mid-run aborts at once; no further strobes are issued.
- All outputs are registered except load_ready, which is combinational: (state==IDLE) && (count < 2**DEPTH_BITS).
- Loading:
  - A word is accepted on an edge where load_valid && load_ready.
  - The word is written to buf[count], then count increments.
  - When full (count==2**DEPTH_BITS), load_ready=0 and further words are not accepted; no overwrite.
  - In any state other than IDLE, load_ready=0.
- IDLE:
  - clear sets count=0.
  - start with count (after this cycle's load, if any) > 0 moves to ISSUE with pc=0.
  - start with count==0 is ignored.
  - clear and start in the same cycle: clear wins, start ignored.
- ISSUE (exactly 1 cycle):
  - On the edge entering ISSUE, instruction<=buf[pc] and issue_strobe<=1.
  - If buf[pc] opcode == HALT_OP, the HALT word is not issued: instruction<=NOP_WORD, no strobe, go to DONE.
  - Otherwise go to HOLD, or if ISSUE_GAP==0 go directly to end-of-slot handling.
- HOLD (ISSUE_GAP cycles):
  - instruction is held, issue_strobe=0, and an internal gap counter counts down.
- End of slot:
  - If pc == count-1, go to DONE.
  - Otherwise pc increments and the state re-enters ISSUE, so consecutive strobes are exactly 1+ISSUE_GAP cycles apart.
- DONE:
  - instruction=NOP_WORD, done=1, busy=0, pc holds the last value.
  - clear returns to IDLE with count=0.
  - start re-runs from pc=0 (to ISSUE).
  - clear wins over start.
- clear is ignored in ISSUE/HOLD.

Optional Feature:
- Macro: INSTR_SEQ_LOOP_EN.
- Defined:
  - At end of slot with pc==count-1 and no HALT, pc wraps to 0 and issuing continues indefinitely.
  - A start pulse while busy sets a stop flag; the run finishes the current slot, then goes to DONE.
  - HALT_OP still terminates the run.
- Not defined:
  - A run ends after the last word.
  - start while busy is ignored.

Test Plan:
- Load 3 words 20'h10203, 20'h21104, 20'h30001, then pulse start (ISSUE_GAP=3) -> strobes 4 cycles apart with instruction = the three words in order; pc 0,1,2; after the third slot, done=1 and instruction=20'h00000.
- Load 16 words, then drive a 17th with load_valid=1 -> load_ready=0 after the 16th, count=16, and the 17th word is never issued.
- Load 20'h10001, 20'hF0000, 20'h20002 and start -> exactly one strobe (20'h10001), then DONE, pc=1; 20'h20002 is never driven.
- Assert start with count=0 -> state stays IDLE, no strobe, busy=0. Assert clear+start in DONE -> IDLE, count=0, no strobe.
- Assert rst in the HOLD cycle of slot 2 of a 3-word run -> the same cycle shows instruction=NOP_WORD, pc=0, count=0, busy=0, and no later strobe.
- With INSTR_SEQ_LOOP_EN: load 2 words and start -> strobe sequence word0, word1, word0, word1; start pulsed during slot 4 -> DONE after slot 4 completes.
